// File: rtl/cp_cmd_seq_pkg.sv
// Shared definitions for the control-panel command sequencer: command type codes,
// FSM state encodings and the strobe bundle driven toward the panel input decoder.
package cp_cmd_seq_pkg;

  // Command type lives in byte0[0:2] (bit 0 = MSB of the byte)
  localparam logic [2:0] CP_CMD_KEYS = 3'b001;
  localparam logic [2:0] CP_CMD_ROT  = 3'b010;
  localparam logic [2:0] CP_CMD_FN   = 3'b100;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DAT_HI = 3'd1,
    ST_DAT_LO = 3'd2,
    ST_WAIT   = 3'd3,
    ST_STROBE = 3'd4,
    ST_GAP    = 3'd5
  } state_e;

  typedef struct packed {
    logic ready;
    logic cpd;
    logic cpr;
    logic cpf;
  } cp_stb_t;

  // Strobe set for a committed frame of the given type; ready always qualifies it
  function automatic cp_stb_t stb_for(input logic [2:0] typ);
    cp_stb_t s;
    s.ready = 1'b1;
    s.cpd   = (typ == CP_CMD_KEYS);
    s.cpr   = (typ == CP_CMD_ROT);
    s.cpf   = (typ == CP_CMD_FN);
    return s;
  endfunction

endpackage

// File: rtl/cp_cmd_seq_if.sv
// Byte link from the UART receiver plus the command bus toward the panel input decoder.
// Byte-wide fields use ascending ranges: index 0 is the MSB.
interface cp_cmd_seq_if;
  logic [0:7]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        cp_busy;
  logic        ready;
  logic        cpd;
  logic        cpr;
  logic        cpf;
  logic [0:7]  a1;
  logic [0:15] a3;
  logic        err;

  // Sequencer side
  modport slave (
    input  rx_data, rx_valid, cp_busy,
    output rx_ready, ready, cpd, cpr, cpf, a1, a3, err
  );

  // Host/decoder side
  modport master (
    output rx_data, rx_valid, cp_busy,
    input  rx_ready, ready, cpd, cpr, cpf, a1, a3, err
  );
endinterface

// File: rtl/cp_cmd_seq.sv
// Control-panel command sequencer: assembles host bytes into frames, waits for the CPU
// side to be free, then issues one registered ready+cpd/cpr/cpf strobe followed by a
// fixed idle gap. Keys frames that stall between bytes are dropped with an err pulse.
module cp_cmd_seq
  import cp_cmd_seq_pkg::*;
#(
  parameter int TIMEOUT = 50000,
  parameter int GAP     = 4
) (
  input  logic         clk_sys,
  input  logic         rst_n,
  cp_cmd_seq_if.slave  bus
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int GW = $clog2(GAP + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
  localparam logic [GW-1:0] GLAST = GW'(GAP - 1);

  state_e         state_q, state_d;
  cp_stb_t        stb_q, stb_d;
  logic           err_q, err_d;
  logic [TW-1:0]  tcnt_q, tcnt_d;
  logic [GW-1:0]  gcnt_q, gcnt_d;
  logic [0:7]     a1_q, a1_d;
  logic [0:15]    a3_q, a3_d;
  logic           rx_ready;
  logic           acc;

  // Byte intake is open only while assembling a frame
  assign rx_ready = (state_q == ST_IDLE) || (state_q == ST_DAT_HI) || (state_q == ST_DAT_LO);
  assign acc      = bus.rx_valid & rx_ready;

  assign bus.rx_ready = rx_ready;
  assign bus.ready    = stb_q.ready;
  assign bus.cpd      = stb_q.cpd;
  assign bus.cpr      = stb_q.cpr;
  assign bus.cpf      = stb_q.cpf;
  assign bus.err      = err_q;
  assign bus.a1       = a1_q;
  assign bus.a3       = a3_q;

  // Next-state and next-output decode; strobes are computed one cycle ahead so they
  // come straight off flops
  always_comb begin
    state_d = state_q;
    stb_d   = '0;
    err_d   = 1'b0;
    tcnt_d  = tcnt_q;
    gcnt_d  = gcnt_q;
    a1_d    = a1_q;
    a3_d    = a3_q;
    case (state_q)
      ST_IDLE: begin
        tcnt_d = '0;
        gcnt_d = '0;
        if (acc) begin
          case (bus.rx_data[0:2])
            CP_CMD_KEYS: begin
              a1_d    = bus.rx_data;
              state_d = ST_DAT_HI;
            end
            CP_CMD_ROT, CP_CMD_FN: begin
              a1_d    = bus.rx_data;
              state_d = ST_WAIT;
            end
            default: err_d = 1'b1;  // byte dropped, a1 untouched
          endcase
        end
      end
      ST_DAT_HI: begin
        if (acc) begin
          a3_d[0:7] = bus.rx_data;
          tcnt_d    = '0;
          state_d   = ST_DAT_LO;
        end else if (tcnt_q == TLAST) begin
          err_d   = 1'b1;
          tcnt_d  = '0;
          state_d = ST_IDLE;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      ST_DAT_LO: begin
        if (acc) begin
          a3_d[8:15] = bus.rx_data;
          tcnt_d     = '0;
          state_d    = ST_WAIT;
        end else if (tcnt_q == TLAST) begin
          err_d   = 1'b1;
          tcnt_d  = '0;
          state_d = ST_IDLE;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      ST_WAIT: begin
        // Once busy is seen low the strobe is committed regardless of later busy
        if (!bus.cp_busy) begin
          stb_d   = stb_for(a1_q[0:2]);
          state_d = ST_STROBE;
        end
      end
      ST_STROBE: begin
        gcnt_d  = '0;
        state_d = ST_GAP;
      end
      ST_GAP: begin
        if (gcnt_q == GLAST) begin
          gcnt_d  = '0;
          state_d = ST_IDLE;
        end else begin
          gcnt_d = gcnt_q + GW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, frame registers, counters and strobe flops
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      stb_q   <= '0;
      err_q   <= 1'b0;
      tcnt_q  <= '0;
      gcnt_q  <= '0;
      a1_q    <= '0;
      a3_q    <= '0;
    end else begin
      state_q <= state_d;
      stb_q   <= stb_d;
      err_q   <= err_d;
      tcnt_q  <= tcnt_d;
      gcnt_q  <= gcnt_d;
      a1_q    <= a1_d;
      a3_q    <= a3_d;
    end
  end

endmodule

// File: tb/tb_cp_cmd_seq.sv
// Directed bench for cp_cmd_seq with a short timeout so the keys-frame drop is reachable.
module tb_cp_cmd_seq;
  localparam int TIMEOUT = 20;
  localparam int GAP     = 4;

  logic clk_sys = 1'b0;
  logic rst_n   = 1'b0;
  int   errors  = 0;
  int   checks  = 0;

  cp_cmd_seq_if bus();

  cp_cmd_seq #(.TIMEOUT(TIMEOUT), .GAP(GAP)) dut (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  // Present a byte and return 1ns after the edge that consumed it (rx_valid left high)
  task automatic send_byte(input logic [7:0] b);
    int n;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    n = 0;
    while (!bus.rx_ready && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (!bus.rx_ready) begin
      errors++;
      $display("FAIL send_byte: rx_ready=%0b after %0d cycles, required 1", bus.rx_ready, n);
    end
    tick();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!bus.rx_ready && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (!bus.rx_ready) begin
      errors++;
      $display("FAIL wait_idle: rx_ready=%0b after %0d cycles, required 1", bus.rx_ready, n);
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({bus.rx_ready, bus.ready, bus.cpd, bus.cpr, bus.cpf, bus.err} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_flags: got %b, required 100000",
               {bus.rx_ready, bus.ready, bus.cpd, bus.cpr, bus.cpf, bus.err});
    end
    checks++;
    if (bus.a1 !== 8'h00 || bus.a3 !== 16'h0000) begin
      errors++;
      $display("FAIL reset_regs: a1=%h a3=%h, required 00 0000", bus.a1, bus.a3);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_rotary();
    int low;
    send_byte(8'h45);
    bus.rx_valid = 1'b0;
    checks++;
    if (bus.a1 !== 8'h45 || bus.ready !== 1'b0 || bus.rx_ready !== 1'b0) begin
      errors++;
      $display("FAIL rot_wait: a1=%h ready=%b rx_ready=%b, required 45 0 0",
               bus.a1, bus.ready, bus.rx_ready);
    end
    tick();
    checks++;
    if ({bus.ready, bus.cpd, bus.cpr, bus.cpf, bus.rx_ready} !== 5'b10100) begin
      errors++;
      $display("FAIL rot_strobe: rdy/cpd/cpr/cpf/rx_ready=%b, required 10100",
               {bus.ready, bus.cpd, bus.cpr, bus.cpf, bus.rx_ready});
    end
    low = 2;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (bus.rx_ready) break;
      low++;
    end
    checks++;
    if (low != 2 + GAP) begin
      errors++;
      $display("FAIL rot_rx_ready_low: %0d cycles, required %0d", low, 2 + GAP);
    end
  endtask

  task automatic test_keys();
    int extra;
    send_byte(8'h20);
    send_byte(8'hAB);
    send_byte(8'hCD);
    bus.rx_valid = 1'b0;
    checks++;
    if (bus.a3 !== 16'hABCD || bus.a1 !== 8'h20 || bus.ready !== 1'b0) begin
      errors++;
      $display("FAIL keys_regs: a1=%h a3=%h ready=%b, required 20 abcd 0", bus.a1, bus.a3, bus.ready);
    end
    tick();
    checks++;
    if ({bus.ready, bus.cpd, bus.cpr, bus.cpf} !== 4'b1100) begin
      errors++;
      $display("FAIL keys_strobe: rdy/cpd/cpr/cpf=%b, required 1100",
               {bus.ready, bus.cpd, bus.cpr, bus.cpf});
    end
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.ready || bus.cpd) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL keys_single: %0d extra strobe cycles, required 0", extra);
    end
    wait_idle();
  endtask

  task automatic test_busy();
    int seen;
    bus.cp_busy = 1'b1;
    send_byte(8'h95);
    bus.rx_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.ready || bus.cpf) seen++;
      tick();
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL busy_hold: %0d strobe cycles while busy, required 0", seen);
    end
    bus.cp_busy = 1'b0;
    tick();
    checks++;
    if ({bus.ready, bus.cpd, bus.cpr, bus.cpf} !== 4'b1001) begin
      errors++;
      $display("FAIL busy_strobe: rdy/cpd/cpr/cpf=%b, required 1001",
               {bus.ready, bus.cpd, bus.cpr, bus.cpf});
    end
    checks++;
    if (bus.a1[3] !== 1'b1 || bus.a1[4:7] !== 4'h5) begin
      errors++;
      $display("FAIL fn_fields: fn_v=%b fn=%h, required 1 5", bus.a1[3], bus.a1[4:7]);
    end
    tick();
    checks++;
    if (bus.ready !== 1'b0 || bus.cpf !== 1'b0) begin
      errors++;
      $display("FAIL busy_after: ready=%b cpf=%b, required 0 0", bus.ready, bus.cpf);
    end
    wait_idle();
  endtask

  task automatic test_timeout();
    int errs, cpds, err_at;
    send_byte(8'h20);
    send_byte(8'h12);
    bus.rx_valid = 1'b0;
    errs = 0; cpds = 0; err_at = -1;
    for (int k = 1; k <= TIMEOUT + 10; k++) begin
      tick();
      if (bus.err) begin
        errs++;
        if (err_at < 0) err_at = k;
      end
      if (bus.cpd || bus.ready) cpds++;
    end
    checks++;
    if (errs != 1 || err_at != TIMEOUT) begin
      errors++;
      $display("FAIL tmo_err: %0d pulses at cycle %0d, required 1 at %0d", errs, err_at, TIMEOUT);
    end
    checks++;
    if (cpds != 0 || bus.rx_ready !== 1'b1) begin
      errors++;
      $display("FAIL tmo_nostrobe: strobes=%0d rx_ready=%b, required 0 1", cpds, bus.rx_ready);
    end
    checks++;
    if (bus.a3 !== 16'h12CD) begin
      errors++;
      $display("FAIL tmo_partial: a3=%h, required 12cd", bus.a3);
    end
  endtask

  task automatic test_invalid();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    send_byte(8'hE0);
    bus.rx_valid = 1'b0;
    checks++;
    if (bus.err !== 1'b1 || bus.a1 !== 8'h00 || bus.rx_ready !== 1'b1) begin
      errors++;
      $display("FAIL inv_err: err=%b a1=%h rx_ready=%b, required 1 00 1", bus.err, bus.a1, bus.rx_ready);
    end
    tick();
    checks++;
    if (bus.err !== 1'b0 || bus.ready !== 1'b0) begin
      errors++;
      $display("FAIL inv_once: err=%b ready=%b, required 0 0", bus.err, bus.ready);
    end
    send_byte(8'h43);
    bus.rx_valid = 1'b0;
    tick();
    checks++;
    if ({bus.ready, bus.cpr} !== 2'b11 || bus.a1 !== 8'h43) begin
      errors++;
      $display("FAIL inv_recover: ready=%b cpr=%b a1=%h, required 1 1 43", bus.ready, bus.cpr, bus.a1);
    end
    wait_idle();
  endtask

  task automatic test_back_to_back();
    int n;
    send_byte(8'h45);
    bus.rx_data = 8'h46;  // next byte held while the sequencer is closed
    tick();
    checks++;
    if (bus.cpr !== 1'b1 || bus.a1 !== 8'h45) begin
      errors++;
      $display("FAIL b2b_first: cpr=%b a1=%h, required 1 45", bus.cpr, bus.a1);
    end
    n = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      n++;
      if (bus.ready) break;
    end
    bus.rx_valid = 1'b0;
    checks++;
    if (n != 3 + GAP || bus.cpr !== 1'b1 || bus.a1 !== 8'h46) begin
      errors++;
      $display("FAIL b2b_second: %0d cycles cpr=%b a1=%h, required %0d 1 46", n, bus.cpr, bus.a1, 3 + GAP);
    end
    wait_idle();
  endtask

  task automatic test_reset_mid();
    send_byte(8'h20);
    send_byte(8'h55);
    bus.rx_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.rx_ready, bus.ready, bus.cpd, bus.cpr, bus.cpf, bus.err} !== 6'b100000 ||
        bus.a3 !== 16'h0000 || bus.a1 !== 8'h00) begin
      errors++;
      $display("FAIL rst_mid_frame: flags=%b a1=%h a3=%h, required 100000 00 0000",
               {bus.rx_ready, bus.ready, bus.cpd, bus.cpr, bus.cpf, bus.err}, bus.a1, bus.a3);
    end
    tick();
    rst_n = 1'b1;
    send_byte(8'h41);
    bus.rx_valid = 1'b0;
    tick();
    checks++;
    if ({bus.ready, bus.cpr} !== 2'b11 || bus.a1 !== 8'h41) begin
      errors++;
      $display("FAIL rst_new_frame: ready=%b cpr=%b a1=%h, required 1 1 41", bus.ready, bus.cpr, bus.a1);
    end
    rst_n = 1'b0;  // in the strobe cycle: strobes must drop without a clock
    #1;
    checks++;
    if (bus.ready !== 1'b0 || bus.cpr !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_strobe: ready=%b cpr=%b, required 0 0", bus.ready, bus.cpr);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    bus.cp_busy  = 1'b0;
    test_reset();
    test_rotary();
    test_keys();
    test_busy();
    test_timeout();
    test_invalid();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
